// File: rtl/clkctrl_phi2_prog_if.sv
// Bus between the CPU-clock switch and its environment: host clock, controls, CPU clock and status.
interface clkctrl_phi2_prog_if #(
   parameter int DIV_W     = 4,
   parameter int DEL_SEL_W = 2
);
   logic                 lsclk_in;
   logic                 hsclk_sel;
   logic [DIV_W-1:0]     cpuclk_div;
   logic [DEL_SEL_W-1:0] delay_sel;
   logic                 clkout;
   logic                 hsclk_selected;
   logic                 lsclk_selected;
   logic                 switch_busy;
   logic                 ls_timeout;

   modport master (
      output lsclk_in, hsclk_sel, cpuclk_div, delay_sel,
      input  clkout, hsclk_selected, lsclk_selected, switch_busy, ls_timeout
   );

   modport slave (
      input  lsclk_in, hsclk_sel, cpuclk_div, delay_sel,
      output clkout, hsclk_selected, lsclk_selected, switch_busy, ls_timeout
   );
endinterface

// File: rtl/clkctrl_phi2_prog.sv
// CPU clock switch: programmable hsclk divide or delayed host clock, every switch parked
// with the output high so neither phase is ever shortened.
module clkctrl_phi2_prog #(
   parameter int DIV_W     = 4,
   parameter int DEL_DEPTH = 4,
   parameter int DEL_SEL_W = 2,
   parameter int TMO_W     = 8
) (
   input  logic                   hsclk_in,
   input  logic                   rst_b,
   clkctrl_phi2_prog_if.slave     bus
);
   typedef enum logic [1:0] {LS_RUN, LS_PARK, HS_RUN, HS_PARK} state_t;

   state_t               r_state, w_nxt;
   logic [DEL_DEPTH-1:0] r_del;
   logic                 r_tap_prev, r_sel_m, r_sel_s;
   logic [DIV_W-1:0]     r_cnt, r_div_l;
   logic                 r_hs_ph;
   logic [TMO_W-1:0]     r_tmo;
   logic                 r_clkout, r_hs_selected, r_ls_selected, r_busy, r_timeout;
   logic                 w_tap, w_rise, w_wrap, w_hs_load, w_hs_run, w_hs_ph_nxt;

   always_comb begin
      // Out-of-range taps clamp to the deepest stage.
      w_tap = r_del[DEL_DEPTH-1];
      for (int i = 0; i < DEL_DEPTH; i++)
         if (int'(bus.delay_sel) == i) w_tap = r_del[i];
      w_rise = w_tap & ~r_tap_prev;

      w_nxt = r_state;
      case (r_state)
         LS_RUN:  if (r_sel_s && w_tap) w_nxt = LS_PARK;
         LS_PARK: if (!r_sel_s) w_nxt = LS_RUN;
                  else if (!w_tap) w_nxt = HS_RUN;
         HS_RUN:  if (!r_sel_s && r_hs_ph) w_nxt = HS_PARK;
         HS_PARK: if (r_sel_s) w_nxt = HS_RUN;
                  else if (w_rise) w_nxt = LS_RUN;
         default: w_nxt = LS_RUN;
      endcase

      w_wrap      = (r_cnt == r_div_l);
      w_hs_load   = (r_state != HS_RUN) && (w_nxt == HS_RUN);
      w_hs_run    = (r_state == HS_RUN) && (w_nxt == HS_RUN);
      w_hs_ph_nxt = w_hs_load ? 1'b1 : ((w_hs_run && w_wrap) ? ~r_hs_ph : r_hs_ph);
   end

   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         r_state       <= LS_RUN;
         r_del         <= '0;
         r_tap_prev    <= 1'b0;
         r_sel_m       <= 1'b0;
         r_sel_s       <= 1'b0;
         r_cnt         <= '0;
         r_div_l       <= '0;
         r_hs_ph       <= 1'b0;
         r_tmo         <= '0;
         r_clkout      <= 1'b0;
         r_hs_selected <= 1'b0;
         r_ls_selected <= 1'b1;
         r_busy        <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_del      <= {r_del[DEL_DEPTH-2:0], bus.lsclk_in};
         r_tap_prev <= w_tap;
         r_sel_m    <= bus.hsclk_sel;
         r_sel_s    <= r_sel_m;
         r_state    <= w_nxt;
         r_hs_ph    <= w_hs_ph_nxt;

         // An abort out of HS_PARK keeps the divide latched before the park.
         if (w_hs_load) begin
            r_cnt <= '0;
            if (r_state == LS_PARK) r_div_l <= bus.cpuclk_div;
         end else if (w_hs_run) begin
            if (w_wrap) begin
               r_cnt <= '0;
               if (!r_hs_ph) r_div_l <= bus.cpuclk_div;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

         if (r_state == HS_PARK && w_nxt == HS_PARK) begin
            if (&r_tmo) r_timeout <= 1'b1;
            else        r_tmo     <= r_tmo + 1'b1;
         end else begin
            r_tmo <= '0;
         end

         case (w_nxt)
            LS_RUN:  r_clkout <= w_tap;
            HS_RUN:  r_clkout <= w_hs_ph_nxt;
            default: r_clkout <= 1'b1;
         endcase
         r_hs_selected <= (w_nxt == HS_RUN);
         r_ls_selected <= (w_nxt == LS_RUN);
         r_busy        <= (w_nxt == LS_PARK) || (w_nxt == HS_PARK);
      end
   end

   assign bus.clkout         = r_clkout;
   assign bus.hsclk_selected = r_hs_selected;
   assign bus.lsclk_selected = r_ls_selected;
   assign bus.switch_busy    = r_busy;
   assign bus.ls_timeout     = r_timeout;
endmodule

// File: tb/tb_clkctrl_phi2_prog.sv
// Bench for clkctrl_phi2_prog: per-cycle reference model plus directed phase measurements.
module tb_clkctrl_phi2_prog;
   localparam int DIV_W = 4, DEL_DEPTH = 4, DEL_SEL_W = 2, TMO_W = 8;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   int   total = 0, bad = 0;

   clkctrl_phi2_prog_if #(.DIV_W(DIV_W), .DEL_SEL_W(DEL_SEL_W)) bus ();

   clkctrl_phi2_prog #(.DIV_W(DIV_W), .DEL_DEPTH(DEL_DEPTH), .DEL_SEL_W(DEL_SEL_W), .TMO_W(TMO_W))
      dut (.hsclk_in(clk), .rst_b(rst_b), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // host clock source: square wave of ls_half hsclk cycles per phase, or held low
   int ls_half = 8;
   bit ls_hold = 0;
   initial begin
      int c;
      c = 0;
      bus.lsclk_in = 1'b0;
      forever begin
         @(negedge clk);
         if (ls_hold) begin
            bus.lsclk_in = 1'b0;
            c = 0;
         end else begin
            c++;
            if (c >= ls_half) begin
               bus.lsclk_in = ~bus.lsclk_in;
               c = 0;
            end
         end
      end
   end

   // reference model: mode 0 LS, 1 LS park, 2 HS, 3 HS park
   bit m_lh[DEL_DEPTH];
   bit m_sh1, m_sh2, m_lvl, m_tflag, m_out, m_prev;
   int m_mode, m_half, m_left, m_tc;

   task automatic model_step();
      int idx, nm;
      bit tap, rise;
      if (!rst_b) begin
         foreach (m_lh[i]) m_lh[i] = 0;
         m_sh1 = 0; m_sh2 = 0; m_lvl = 0; m_tflag = 0; m_out = 0; m_prev = 0;
         m_mode = 0; m_half = 1; m_left = 0; m_tc = 0;
         return;
      end
      idx  = (int'(bus.delay_sel) > DEL_DEPTH-1) ? DEL_DEPTH-1 : int'(bus.delay_sel);
      tap  = m_lh[idx];
      rise = tap && !m_prev;
      nm   = m_mode;
      case (m_mode)
         0: if (m_sh2 && tap) nm = 1;
         1: if (!m_sh2) nm = 0;
            else if (!tap) begin
               nm = 2; m_half = int'(bus.cpuclk_div) + 1; m_lvl = 1; m_left = m_half - 1;
            end
         2: if (!m_sh2 && m_lvl) nm = 3;
            else if (m_left == 0) begin
               m_lvl = !m_lvl;
               if (m_lvl) m_half = int'(bus.cpuclk_div) + 1;
               m_left = m_half - 1;
            end else m_left--;
         default: if (m_sh2) begin
               nm = 2; m_lvl = 1; m_left = m_half - 1;
            end else if (rise) nm = 0;
      endcase
      if (m_mode == 3 && nm == 3) begin
         if (m_tc == (1 << TMO_W) - 1) m_tflag = 1;
         else m_tc++;
      end else m_tc = 0;
      m_out  = (nm == 0) ? tap : (nm == 2) ? m_lvl : 1'b1;
      m_mode = nm;
      for (int i = DEL_DEPTH-1; i > 0; i--) m_lh[i] = m_lh[i-1];
      m_lh[0] = bus.lsclk_in;
      m_sh2 = m_sh1; m_sh1 = bus.hsclk_sel;
      m_prev = tap;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("clkout", bus.clkout, m_out);
         chk("hs_sel", bus.hsclk_selected, m_mode == 2);
         chk("ls_sel", bus.lsclk_selected, m_mode == 0);
         chk("busy", bus.switch_busy, m_mode == 1 || m_mode == 3);
         chk("timeout", bus.ls_timeout, m_tflag);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   function automatic logic pick(input int w);
      case (w)
         0: return bus.hsclk_selected;
         1: return bus.lsclk_selected;
         2: return bus.switch_busy;
         default: return bus.clkout;
      endcase
   endfunction

   task automatic wait_for(input int w, input logic v, input string nm);
      int n;
      n = 0;
      while (pick(w) !== v && n < 200) begin
         cyc(1);
         n++;
      end
      chk(nm, n < 200, 1);
   endtask

   task automatic measure(output int hi, output int lo);
      wait_for(3, 1'b0, "m_low0");
      wait_for(3, 1'b1, "m_rise");
      hi = 0; lo = 0;
      while (bus.clkout === 1'b1 && hi < 100) begin cyc(1); hi++; end
      while (bus.clkout === 1'b0 && lo < 100) begin cyc(1); lo++; end
   endtask

   initial begin
      int hi, lo, k;
      bus.hsclk_sel  = 1'b0;
      bus.cpuclk_div = 4'd1;
      bus.delay_sel  = 2'd1;
      cyc(3);
      chk("rst_clkout", bus.clkout, 0);
      chk("rst_ls_sel", bus.lsclk_selected, 1);
      chk("rst_hs_sel", bus.hsclk_selected, 0);
      chk("rst_busy", bus.switch_busy, 0);
      chk("rst_tmo", bus.ls_timeout, 0);
      rst_b = 1'b1;
      cyc(20);

      // host path: sampled on one edge, visible two edges later
      wait_for(3, 1'b0, "ls_low");
      k = 0;
      while (bus.lsclk_in !== 1'b0 && k < 40) begin cyc(1); k++; end
      while (bus.lsclk_in !== 1'b1 && k < 80) begin cyc(1); k++; end
      k = 0;
      while (bus.clkout !== 1'b1 && k < 40) begin cyc(1); k++; end
      chk("ls_delay_edges", k, 3);
      chk("ls_path_sel", bus.lsclk_selected, 1);

      // switch to hs, div 1 -> 2/2
      bus.hsclk_sel = 1'b1;
      wait_for(0, 1'b1, "to_hs");
      measure(hi, lo);
      chk("div1_hi", hi, 2);
      chk("div1_lo", lo, 2);
      cyc(1);
      bus.cpuclk_div = 4'd3;
      measure(hi, lo);
      chk("div3_hi", hi, 4);
      chk("div3_lo", lo, 4);

      // back to host clock
      bus.hsclk_sel = 1'b0;
      wait_for(1, 1'b1, "to_ls");
      cyc(10);

      // abort inside HS_PARK
      bus.cpuclk_div = 4'd1;
      bus.hsclk_sel = 1'b1;
      wait_for(0, 1'b1, "to_hs2");
      ls_hold = 1;
      cyc(8);
      bus.hsclk_sel = 1'b0;
      wait_for(2, 1'b1, "hs_park");
      cyc(3);
      bus.hsclk_sel = 1'b1;
      wait_for(0, 1'b1, "abort_back");
      k = 0;
      while (bus.clkout === 1'b1 && k < 50) begin cyc(1); k++; end
      chk("abort_hi", k, 2);

      // lost host clock
      bus.hsclk_sel = 1'b0;
      wait_for(2, 1'b1, "hs_park2");
      cyc(255);
      chk("tmo_255", bus.ls_timeout, 0);
      cyc(1);
      chk("tmo_256", bus.ls_timeout, 1);
      chk("tmo_clk", bus.clkout, 1);
      chk("tmo_busy", bus.switch_busy, 1);
      rst_b = 1'b0;
      #1;
      chk("tmo_rst", bus.ls_timeout, 0);
      chk("tmo_rst_clk", bus.clkout, 0);
      cyc(2);
      rst_b = 1'b1;
      ls_hold = 0;
      cyc(20);

      // reset mid-switch
      bus.hsclk_sel = 1'b1;
      wait_for(2, 1'b1, "ls_park");
      rst_b = 1'b0;
      #1;
      chk("mid_clk", bus.clkout, 0);
      chk("mid_ls_sel", bus.lsclk_selected, 1);
      chk("mid_busy", bus.switch_busy, 0);
      bus.hsclk_sel = 1'b0;
      cyc(2);
      rst_b = 1'b1;

      // random traffic against the model
      for (int it = 0; it < 200; it++) begin
         ls_half        = int'($urandom_range(2, 10));
         bus.delay_sel  = 2'($urandom_range(0, 3));
         bus.cpuclk_div = 4'($urandom_range(0, 5));
         bus.hsclk_sel  = 1'($urandom_range(0, 1));
         ls_hold        = ($urandom_range(0, 15) == 0);
         cyc(int'($urandom_range(1, 40)));
      end
      ls_hold = 0;
      cyc(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
